// File: rtl/cache_wb_data.sv
// cache_wb_data: writeback data store for one cache bank.
//
// Holds line data and per-byte dirty masks. It serves read, write, fill and
// evict requests from the bank pipeline. Evicted and flushed lines drain to
// memory as BEAT_SIZE-byte beats, and only beats that hold dirty bytes are
// sent.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_*                 request channel (valid/ready); op 0 read, 1 write,
//                         2 fill, 3 evict; addressed by line/way/word select
//   rsp_valid, rsp_data   read data, one cycle after the read is accepted
//   wb_*                  writeback beat channel (valid/ready) with source
//                         line/way, beat index, beat data and dirty byte mask
//   flush_start           starts a walk over every entry (only sampled in IDLE)
//   flush_busy            high while the flush walk is in progress
//   flush_done            one-cycle pulse when the walk completes
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | accepts requests; flush_start has priority over req_valid
//   S_DRAIN | sends the non-empty beats of the drain buffer, lowest beat first
//   S_SCAN  | examines one entry per cycle; dirty entries are captured and
//           | drained, and the walk then resumes at the following entry
module cache_wb_data #(
  parameter int CACHE_SIZE = 1024,
  parameter int LINE_SIZE  = 16,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 2,
  parameter int WORD_SIZE  = 4,
  parameter int BEAT_SIZE  = 8,
  localparam int NUM_LINES = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
  localparam int WORDS     = LINE_SIZE / WORD_SIZE,
  localparam int BEATS     = LINE_SIZE / BEAT_SIZE,
  localparam int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int WSEL_W    = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [LINE_W-1:0]        req_line,
  input  logic [WAY_W-1:0]         req_way,
  input  logic [WSEL_W-1:0]        req_wsel,
  input  logic [WORD_SIZE-1:0]     req_byteen,
  input  logic [8*WORD_SIZE-1:0]   req_wdata,
  input  logic [8*LINE_SIZE-1:0]   req_fill_data,
  output logic                     rsp_valid,
  output logic [8*WORD_SIZE-1:0]   rsp_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [LINE_W-1:0]        wb_line,
  output logic [WAY_W-1:0]         wb_way,
  output logic [BEAT_W-1:0]        wb_beat,
  output logic [8*BEAT_SIZE-1:0]   wb_data,
  output logic [BEAT_SIZE-1:0]     wb_byteen,
  input  logic                     flush_start,
  output logic                     flush_busy,
  output logic                     flush_done
);

  localparam int LINE_BITS = 8 * LINE_SIZE;
  localparam int WORD_BITS = 8 * WORD_SIZE;
  localparam int BEAT_BITS = 8 * BEAT_SIZE;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_EVICT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 flush_q, flush_d;
  logic                 flush_done_q, flush_done_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_BITS-1:0] rsp_data_q, rsp_data_d;
  logic [LINE_BITS-1:0] drain_data_q, drain_data_d;
  logic [LINE_SIZE-1:0] drain_mask_q, drain_mask_d;
  logic [LINE_W-1:0]    drain_line_q, drain_line_d;
  logic [WAY_W-1:0]     drain_way_q, drain_way_d;
  logic [LINE_W-1:0]    scan_line_q, scan_line_d;
  logic [WAY_W-1:0]     scan_way_q, scan_way_d;
  logic                 scan_end_q, scan_end_d;

  // Storage arrays; data is never reset, dirty masks are.
  logic [LINE_BITS-1:0] data_q  [NUM_LINES][NUM_WAYS];
  logic [LINE_SIZE-1:0] dirty_q [NUM_LINES][NUM_WAYS];

  logic [LINE_W-1:0]    sel_line;
  logic [WAY_W-1:0]     sel_way;
  logic [LINE_BITS-1:0] cur_data;
  logic [LINE_SIZE-1:0] cur_dirty;

  logic [LINE_SIZE-1:0] data_we;
  logic [LINE_BITS-1:0] data_wval;
  logic                 dirty_we;
  logic [LINE_SIZE-1:0] dirty_wval;

  logic [LINE_SIZE-1:0] wmask;
  logic [LINE_SIZE-1:0] beat_clr;
  logic                 beat_found;
  logic [BEAT_W-1:0]    beat_idx;
  logic                 capture;

  // The scan walk owns the array port in SCAN; otherwise the request does.
  always_comb begin
    sel_line = req_line;
    sel_way  = req_way;
    if (state_q == S_SCAN) begin
      sel_line = scan_line_q;
      sel_way  = scan_way_q;
    end
  end

  assign cur_data  = data_q[sel_line][sel_way];
  assign cur_dirty = dirty_q[sel_line][sel_way];

  assign wmask    = LINE_SIZE'(req_byteen) << (req_wsel * WORD_SIZE);
  assign beat_clr = LINE_SIZE'({BEAT_SIZE{1'b1}}) << (beat_idx * BEAT_SIZE);

  // Lowest beat with any dirty byte; empty beats are skipped without a bubble.
  always_comb begin
    beat_found = 1'b0;
    beat_idx   = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (|drain_mask_q[b*BEAT_SIZE +: BEAT_SIZE]) begin
        beat_found = 1'b1;
        beat_idx   = BEAT_W'(b);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    flush_done_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    drain_data_d = drain_data_q;
    drain_mask_d = drain_mask_q;
    drain_line_d = drain_line_q;
    drain_way_d  = drain_way_q;
    scan_line_d  = scan_line_q;
    scan_way_d   = scan_way_q;
    scan_end_d   = scan_end_q;
    data_we      = '0;
    data_wval    = cur_data;
    dirty_we     = 1'b0;
    dirty_wval   = cur_dirty;
    req_ready    = 1'b0;
    wb_valid     = 1'b0;
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = ~flush_start;
        if (flush_start) begin
          state_d     = S_SCAN;
          flush_d     = 1'b1;
          scan_line_d = '0;
          scan_way_d  = '0;
          scan_end_d  = 1'b0;
        end else if (req_valid) begin
          case (req_op)
            OP_READ: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = cur_data[req_wsel*WORD_BITS +: WORD_BITS];
            end
            OP_WRITE: begin
              data_we    = wmask;
              data_wval  = {WORDS{req_wdata}};
              dirty_we   = 1'b1;
              dirty_wval = cur_dirty | wmask;
            end
            OP_FILL: begin
              data_we    = '1;
              data_wval  = req_fill_data;
              dirty_we   = 1'b1;
              dirty_wval = '0;
            end
            default: capture = 1'b1;
          endcase
        end
      end

      S_DRAIN: begin
        wb_valid = beat_found;
        if (beat_found && wb_ready) begin
          drain_mask_d = drain_mask_q & ~beat_clr;
        end
        if (drain_mask_d == '0) begin
          state_d = flush_q ? S_SCAN : S_IDLE;
        end
      end

      S_SCAN: begin
        if (scan_end_q) begin
          state_d      = S_IDLE;
          flush_d      = 1'b0;
          flush_done_d = 1'b1;
        end else begin
          // Advance now so a drained entry returns to the following one.
          if (scan_way_q == WAY_W'(NUM_WAYS - 1)) begin
            scan_way_d = '0;
            if (scan_line_q == LINE_W'(NUM_LINES - 1)) begin
              scan_end_d = 1'b1;
            end else begin
              scan_line_d = scan_line_q + 1'b1;
            end
          end else begin
            scan_way_d = scan_way_q + 1'b1;
          end
          capture = |cur_dirty;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Evict and dirty scan entries share one capture path into the drain buffer.
    if (capture) begin
      drain_data_d = cur_data;
      drain_mask_d = cur_dirty;
      drain_line_d = sel_line;
      drain_way_d  = sel_way;
      dirty_we     = 1'b1;
      dirty_wval   = '0;
      state_d      = S_DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      flush_q      <= 1'b0;
      flush_done_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      drain_mask_q <= '0;
      drain_line_q <= '0;
      drain_way_q  <= '0;
      scan_line_q  <= '0;
      scan_way_q   <= '0;
      scan_end_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_q      <= flush_d;
      flush_done_q <= flush_done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      drain_mask_q <= drain_mask_d;
      drain_line_q <= drain_line_d;
      drain_way_q  <= drain_way_d;
      scan_line_q  <= scan_line_d;
      scan_way_q   <= scan_way_d;
      scan_end_q   <= scan_end_d;
    end
  end

  // Drain data is only meaningful where the mask says so; no reset needed.
  always_ff @(posedge clk) begin
    drain_data_q <= drain_data_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LINE_SIZE; i++) begin
        if (data_we[i]) begin
          data_q[sel_line][sel_way][8*i +: 8] <= data_wval[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < NUM_LINES; l++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          dirty_q[l][w] <= '0;
        end
      end
    end else if (dirty_we) begin
      dirty_q[sel_line][sel_way] <= dirty_wval;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign wb_line    = drain_line_q;
  assign wb_way     = drain_way_q;
  assign wb_beat    = beat_idx;
  assign wb_data    = drain_data_q[beat_idx*BEAT_BITS +: BEAT_BITS];
  assign wb_byteen  = drain_mask_q[beat_idx*BEAT_SIZE +: BEAT_SIZE];
  assign flush_busy = flush_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_cache_wb_data.sv
module tb_cache_wb_data;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [2:0]   req_line;
  logic         req_way;
  logic [1:0]   req_wsel;
  logic [3:0]   req_byteen;
  logic [31:0]  req_wdata;
  logic [127:0] req_fill_data;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         wb_valid;
  logic         wb_ready;
  logic [2:0]   wb_line;
  logic         wb_way;
  logic         wb_beat;
  logic [63:0]  wb_data;
  logic [7:0]   wb_byteen;
  logic         flush_start;
  logic         flush_busy;
  logic         flush_done;

  cache_wb_data #(
    .CACHE_SIZE(256), .LINE_SIZE(16), .NUM_BANKS(1),
    .NUM_WAYS(2), .WORD_SIZE(4), .BEAT_SIZE(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_line(req_line), .req_way(req_way), .req_wsel(req_wsel),
    .req_byteen(req_byteen), .req_wdata(req_wdata), .req_fill_data(req_fill_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line), .wb_way(wb_way),
    .wb_beat(wb_beat), .wb_data(wb_data), .wb_byteen(wb_byteen),
    .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain byte arrays and dirty flags per byte.
  logic [7:0] mdata  [8][2][16];
  bit         mdirty [8][2][16];

  // Beat record: {line, way, beat, byteen, data}
  typedef logic [76:0] beat_t;
  beat_t exp_q[$];
  beat_t obs_q[$];

  int c_ready_cyc, c_done_cyc, c_done_cnt, c_unstable, c_zero, c_stall_valid;
  bit c_busy1, c_tmo, c_saw_valid;

  // Move every dirty beat of an entry into the expected queue and clean it.
  task automatic model_capture(input logic [2:0] l, input logic w);
    for (int b = 0; b < 2; b++) begin
      logic [7:0]  m;
      logic [63:0] d;
      m = '0;
      d = '0;
      for (int k = 0; k < 8; k++) begin
        m[k] = mdirty[l][w][b*8+k];
        d[8*k +: 8] = mdata[l][w][b*8+k];
        mdirty[l][w][b*8+k] = 1'b0;
      end
      if (m != 8'h00) exp_q.push_back({l, w, 1'(b), m, d});
    end
  endtask

  task automatic model_flush();
    for (int l = 0; l < 8; l++)
      for (int w = 0; w < 2; w++)
        model_capture(3'(l), 1'(w));
  endtask

  // Issue one request (DUT assumed idle) and update the model.
  task automatic send(input logic [1:0] op, input logic [2:0] l, input logic w,
                      input logic [1:0] ws, input logic [3:0] be, input logic [31:0] wd,
                      input logic [127:0] fd, output logic [31:0] exp_word);
    for (int j = 0; j < 4; j++) exp_word[8*j +: 8] = mdata[l][w][ws*4+j];
    req_valid = 1'b1; req_op = op; req_line = l; req_way = w; req_wsel = ws;
    req_byteen = be; req_wdata = wd; req_fill_data = fd;
    case (op)
      2'd1: for (int j = 0; j < 4; j++)
              if (be[j]) begin
                mdata[l][w][ws*4+j]  = wd[8*j +: 8];
                mdirty[l][w][ws*4+j] = 1'b1;
              end
      2'd2: for (int i = 0; i < 16; i++) begin
              mdata[l][w][i]  = fd[8*i +: 8];
              mdirty[l][w][i] = 1'b0;
            end
      2'd3: model_capture(l, w);
      default: ;
    endcase
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Watch the writeback port until the DUT is back in idle (not flushing).
  task automatic collect(input int stall, input bit rnd, input int maxc);
    beat_t cur, prev_cur;
    bit prev_stall;
    int cyc;
    obs_q.delete();
    c_ready_cyc = -1; c_done_cyc = -1; c_done_cnt = 0; c_unstable = 0;
    c_zero = 0; c_stall_valid = 0; c_busy1 = 1'b0; c_tmo = 1'b0; c_saw_valid = 1'b0;
    prev_stall = 1'b0; prev_cur = '0; cyc = 1;
    forever begin
      if (rnd) wb_ready = 1'($urandom_range(0, 1));
      else     wb_ready = (cyc > stall);
      if (cyc == 1) c_busy1 = flush_busy;
      if (flush_done) begin c_done_cnt++; c_done_cyc = cyc; end
      if (wb_valid) begin
        c_saw_valid = 1'b1;
        cur = {wb_line, wb_way, wb_beat, wb_byteen, wb_data};
        if (wb_byteen == 8'h00) c_zero++;
        if (prev_stall && cur !== prev_cur) c_unstable++;
        if (!wb_ready) c_stall_valid++;
        else obs_q.push_back(cur);
        prev_stall = !wb_ready;
        prev_cur = cur;
      end else begin
        if (prev_stall) c_unstable++;
        prev_stall = 1'b0;
      end
      if (req_ready && !flush_busy) begin c_ready_cyc = cyc; break; end
      if (cyc >= maxc) begin c_tmo = 1'b1; break; end
      @(posedge clk); #1;
      cyc++;
    end
    wb_ready = 1'b1;
  endtask

  task automatic test_reset();
    total++; if (req_ready !== 1'b1)  begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    total++; if (wb_valid !== 1'b0)   begin bad++; $display("FAIL reset_wb_valid got=%b want=0", wb_valid); end
    total++; if (flush_busy !== 1'b0) begin bad++; $display("FAIL reset_flush_busy got=%b want=0", flush_busy); end
    total++; if (flush_done !== 1'b0) begin bad++; $display("FAIL reset_flush_done got=%b want=0", flush_done); end
  endtask

  task automatic fill_all();
    logic [31:0] ew;
    for (int l = 0; l < 8; l++)
      for (int w = 0; w < 2; w++)
        send(2'd2, 3'(l), 1'(w), 2'd0, 4'h0, 32'h0,
             {$urandom, $urandom, $urandom, $urandom}, ew);
  endtask

  task automatic test_evict_dirty();
    logic [31:0] ew;
    exp_q.delete();
    send(2'd2, 3'd3, 1'b1, 2'd0, 4'h0, 32'h0, 128'h0F0E0D0C0B0A09080706050403020100, ew);
    send(2'd1, 3'd3, 1'b1, 2'd2, 4'b0011, 32'hAABBCCDD, 128'h0, ew);
    send(2'd3, 3'd3, 1'b1, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    collect(0, 1'b0, 50);
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL evict_beats got=%0d want=1", obs_q.size()); end
    else begin
      total++;
      if (obs_q[0] !== {3'd3, 1'b1, 1'b1, 8'h03, 64'h0F0E0D0C0B0ACCDD}) begin
        bad++; $display("FAIL evict_beat got=%h want=%h", obs_q[0], {3'd3, 1'b1, 1'b1, 8'h03, 64'h0F0E0D0C0B0ACCDD});
      end
      total++; if (obs_q[0] !== exp_q[0]) begin bad++; $display("FAIL evict_model got=%h want=%h", obs_q[0], exp_q[0]); end
    end
    total++; if (c_ready_cyc != 2) begin bad++; $display("FAIL evict_ready_cyc got=%0d want=2", c_ready_cyc); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ew;
    exp_q.delete();
    send(2'd2, 3'd5, 1'b0, 2'd0, 4'h0, 32'h0, {$urandom, $urandom, $urandom, $urandom}, ew);
    for (int ws = 0; ws < 4; ws++) send(2'd1, 3'd5, 1'b0, 2'(ws), 4'hF, $urandom, 128'h0, ew);
    send(2'd3, 3'd5, 1'b0, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    collect(5, 1'b0, 50);
    total++; if (c_stall_valid != 5) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=5", c_stall_valid); end
    total++; if (c_unstable != 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", c_unstable); end
    total++; if (c_ready_cyc != 8) begin bad++; $display("FAIL bp_ready_cyc got=%0d want=8", c_ready_cyc); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_clean_evict();
    logic [31:0] ew;
    exp_q.delete();
    send(2'd2, 3'd2, 1'b1, 2'd0, 4'h0, 32'h0, {$urandom, $urandom, $urandom, $urandom}, ew);
    send(2'd3, 3'd2, 1'b1, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    collect(0, 1'b0, 50);
    total++; if (c_saw_valid) begin bad++; $display("FAIL clean_wb_valid got=1 want=0"); end
    total++; if (c_ready_cyc != 2) begin bad++; $display("FAIL clean_ready_cyc got=%0d want=2", c_ready_cyc); end
  endtask

  task automatic test_raw();
    logic [31:0]  ew;
    logic [127:0] fd;
    fd = {$urandom, $urandom, $urandom, 32'h55667788};
    send(2'd2, 3'd0, 1'b1, 2'd0, 4'h0, 32'h0, fd, ew);
    send(2'd1, 3'd0, 1'b1, 2'd0, 4'b1000, 32'h11223344, 128'h0, ew);
    send(2'd0, 3'd0, 1'b1, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL raw_rsp_valid got=%b want=1", rsp_valid); end
    total++; if (rsp_data !== 32'h11667788) begin bad++; $display("FAIL raw_rsp_data got=%h want=11667788", rsp_data); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL raw_rsp_pulse got=%b want=0", rsp_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] ew;
    logic [31:0] wd;
    exp_q.delete();
    send(2'd1, 3'd1, 1'b0, 2'd1, 4'hF, $urandom, 128'h0, ew);
    send(2'd1, 3'd6, 1'b1, 2'd3, 4'b0100, $urandom, 128'h0, ew);
    send(2'd1, 3'd6, 1'b1, 2'd0, 4'b0001, $urandom, 128'h0, ew);
    model_flush();
    // A write presented together with flush_start must not be accepted.
    wd = $urandom;
    req_valid = 1'b1; req_op = 2'd1; req_line = 3'd2; req_way = 1'b0;
    req_wsel = 2'd0; req_byteen = 4'hF; req_wdata = wd;
    flush_start = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL flush_prio_ready got=%b want=0", req_ready); end
    @(posedge clk); #1;
    flush_start = 1'b0; req_valid = 1'b0;
    collect(0, 1'b0, 400);
    total++; if (c_tmo) begin bad++; $display("FAIL flush_timeout got=1 want=0"); end
    total++; if (!c_busy1) begin bad++; $display("FAIL flush_busy got=0 want=1"); end
    total++; if (c_done_cnt != 1) begin bad++; $display("FAIL flush_done_cnt got=%0d want=1", c_done_cnt); end
    total++; if (c_done_cyc != 18 + exp_q.size()) begin bad++; $display("FAIL flush_done_cyc got=%0d want=%0d", c_done_cyc, 18 + exp_q.size()); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL flush_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL flush_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    // Second flush: everything is clean now.
    flush_start = 1'b1;
    @(posedge clk); #1;
    flush_start = 1'b0;
    collect(0, 1'b0, 400);
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL reflush_beats got=%0d want=0", obs_q.size()); end
    total++; if (c_done_cyc != 18) begin bad++; $display("FAIL reflush_done_cyc got=%0d want=18", c_done_cyc); end
    send(2'd0, 3'd2, 1'b0, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    total++; if (rsp_data !== ew) begin bad++; $display("FAIL flush_ignored_write got=%h want=%h", rsp_data, ew); end
  endtask

  task automatic test_random();
    logic [31:0] ew;
    logic [1:0]  op;
    for (int it = 0; it < 150; it++) begin
      exp_q.delete();
      op = 2'($urandom_range(0, 3));
      send(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), $urandom, {$urandom, $urandom, $urandom, $urandom}, ew);
      if (op == 2'd0) begin
        total++; if (rsp_valid !== 1'b1 || rsp_data !== ew) begin
          bad++; $display("FAIL rand_read it=%0d got=%b/%h want=1/%h", it, rsp_valid, rsp_data, ew);
        end
      end
      if (op == 2'd3) begin
        collect(0, 1'b1, 200);
        total++; if (obs_q.size() != exp_q.size() || c_zero != 0 || c_unstable != 0) begin
          bad++; $display("FAIL rand_evict it=%0d got=%0d/%0d/%0d want=%0d/0/0", it, obs_q.size(), c_zero, c_unstable, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
          total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat it=%0d got=%h want=%h", it, obs_q[i], exp_q[i]); end
        end
      end
    end
    exp_q.delete();
    model_flush();
    flush_start = 1'b1;
    @(posedge clk); #1;
    flush_start = 1'b0;
    collect(0, 1'b1, 3000);
    total++; if (c_done_cnt != 1 || c_tmo) begin bad++; $display("FAIL rand_flush_done got=%0d want=1", c_done_cnt); end
    total++; if (obs_q.size() != exp_q.size() || c_unstable != 0) begin
      bad++; $display("FAIL rand_flush_beats got=%0d/%0d want=%0d/0", obs_q.size(), c_unstable, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_flush_beat%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] ew;
    exp_q.delete();
    send(2'd1, 3'd4, 1'b0, 2'd3, 4'hF, $urandom, 128'h0, ew);
    send(2'd1, 3'd4, 1'b0, 2'd0, 4'h1, $urandom, 128'h0, ew);
    send(2'd3, 3'd4, 1'b0, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    wb_ready = 1'b0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL rst_stalled_valid got=%b want=1", wb_valid); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b want=0", wb_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    reset = 1'b0;
    wb_ready = 1'b1;
    for (int l = 0; l < 8; l++) for (int w = 0; w < 2; w++) for (int i = 0; i < 16; i++) mdirty[l][w][i] = 1'b0;
    exp_q.delete();
    send(2'd3, 3'd4, 1'b0, 2'd0, 4'h0, 32'h0, 128'h0, ew);
    collect(0, 1'b0, 50);
    total++; if (c_saw_valid) begin bad++; $display("FAIL rst_reevict_valid got=1 want=0"); end
    total++; if (c_ready_cyc != 2) begin bad++; $display("FAIL rst_reevict_ready got=%0d want=2", c_ready_cyc); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_line = 3'd0; req_way = 1'b0;
    req_wsel = 2'd0; req_byteen = 4'h0; req_wdata = 32'h0; req_fill_data = 128'h0;
    wb_ready = 1'b1; flush_start = 1'b0;
    for (int l = 0; l < 8; l++) for (int w = 0; w < 2; w++) for (int i = 0; i < 16; i++) begin
      mdata[l][w][i] = 8'h00; mdirty[l][w][i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    fill_all();
    test_evict_dirty();
    test_backpressure();
    test_clean_evict();
    test_raw();
    test_flush();
    test_random();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_wb_data.md
# cache_wb_data

Writeback cache data store for one cache bank. It holds line data and per-byte dirty masks, serves read, write and fill requests, and drains dirty lines to memory through a valid/ready writeback port in BEAT_SIZE-byte beats. Only dirty beats are sent. A flush mode walks every line and way and writes back all dirty entries. It sits between the bank pipeline (tag/MSHR stages) and the memory request arbiter.

## Interface
- CACHE_SIZE, 1024: cache bytes across all banks
- LINE_SIZE, 16: line bytes
- NUM_BANKS, 1: bank count
- NUM_WAYS, 2: associativity, ≥1
- WORD_SIZE, 4: core word bytes; LINE_SIZE % WORD_SIZE == 0
- BEAT_SIZE, 8: writeback beat bytes; divides LINE_SIZE, ≥ WORD_SIZE
- Derived values:
  - NUM_LINES = CACHE_SIZE/(LINE_SIZE·NUM_BANKS·NUM_WAYS)
  - WORDS = LINE_SIZE/WORD_SIZE
  - BEATS = LINE_SIZE/BEAT_SIZE
- Ports:
  - clk  in  1  clock
  - reset  in  1  synchronous, active-high
  - req_valid  in  1  request present
  - req_ready  out  1  request accepted when req_valid & req_ready
  - req_op  in  2  0 read, 1 write, 2 fill, 3 evict
  - req_line  in  LOG2UP(NUM_LINES)  line index
  - req_way  in  LOG2UP(NUM_WAYS)  way index (binary)
  - req_wsel  in  LOG2UP(WORDS)  word select
  - req_byteen  in  WORD_SIZE  write byte enables
  - req_wdata  in  8·WORD_SIZE  write data
  - req_fill_data  in  8·LINE_SIZE  fill line
  - rsp_valid  out  1  read data valid
  - rsp_data  out  8·WORD_SIZE  read data
  - wb_valid  out  1  writeback beat valid
  - wb_ready  in  1  beat consumed when wb_valid & wb_ready
  - wb_line, wb_way  out  as req_line/req_way  source entry
  - wb_beat  out  LOG2UP(BEATS)  beat index in line
  - wb_data  out  8·BEAT_SIZE  beat data
  - wb_byteen  out  BEAT_SIZE  dirty bytes of beat, never 0 when wb_valid
  - flush_start  in  1  start flush (sampled in IDLE)
  - flush_busy  out  1  flush in progress
  - flush_done  out  1  one-cycle pulse at flush end

## Operation
- Storage: data array NUM_LINES×NUM_WAYS×LINE_SIZE, not reset. Dirty array: same shape, one bit per byte, reset to 0.
- Byte mask for a write: m = req_byteen << (req_wsel·WORD_SIZE), width LINE_SIZE.
- Read: rsp_data = word req_wsel of the entry. Reflects writes accepted in earlier cycles.
- Write: writes the enabled bytes. Dirty mask of the entry |= m.
- Fill: writes the whole line. Dirty mask of the entry cleared.
- Evict: copies the entry's line and dirty mask into a drain buffer, then clears the entry's dirty mask. Data is kept.
- States:
  - IDLE: req_ready = ~flush_start.
  - DRAIN: serves the drain buffer.
    - Presents the lowest-indexed beat whose mask is nonzero.
    - On each handshake, clears that beat's mask bits.
    - When the mask is empty, goes to IDLE, or to SCAN if flushing.
    - A beat with a zero mask is never presented.
  - SCAN: examines entry (line L, way W) in line-major, way-minor order starting at (0,0).
    - Dirty entry: capture as for evict, go to DRAIN, return to the next entry.
    - Clean entry: advance next cycle.
    - After the last entry: flush_done pulses, flush_busy falls, state goes to IDLE.
- req_ready is 0 in DRAIN and SCAN.
- flush_start in IDLE takes priority over req_valid in the same cycle. That request is not accepted.
- flush_start outside IDLE is ignored.

## Timing
- Reset values: req_ready=1, rsp_valid=0, wb_valid=0, flush_busy=0, flush_done=0; dirty array all 0; state IDLE.
- Read accepted in cycle N: rsp_valid=1 with data in N+1 only.
- Write or fill in cycle N is visible to a read accepted in N+1.
- Evict accepted in cycle N:
  - state is DRAIN in N+1;
  - wb_valid may assert in N+1;
  - clean line: wb_valid never asserts, req_ready=1 again in N+2.
- Beat rate: at most one beat per cycle; zero-mask beats are skipped with no bubble. With wb_ready held 1, a line with k dirty beats drains in k cycles after the capture cycle.
- Stalls: while wb_valid & ~wb_ready, all wb_* outputs hold stable.
- Flush: flush_busy=1 from the cycle after flush_start until flush_done.
  - Each clean entry costs 1 cycle.
  - Each dirty entry costs 1 capture cycle plus its drain.
- Reset mid-drain or mid-flush:
  - next cycle wb_valid=0 and state IDLE;
  - drain buffer discarded;
  - all dirty masks 0.

## Test plan
- Dirty write then evict (LINE 16, WORD 4, BEAT 8, 2 ways, CACHE 256):
  - Stimulus: fill (3,1) with 0x0F0E…00; write wsel=2, byteen=4'b0011, data 0xAABBCCDD; evict (3,1).
  - Required: exactly one beat; wb_beat=1, wb_byteen=8'h03, wb_data low bytes 0xDD,0xCC, other bytes 0x0F..0x0A.
- Backpressure:
  - Stimulus: all 16 bytes dirty, evict, wb_ready=0 for 5 cycles.
  - Required: beat 0 held stable for 5 cycles; beats 0 then 1 follow; req_ready stays 0 until the cycle after beat 1's handshake.
- Clean evict:
  - Stimulus: fill then evict same entry.
  - Required: wb_valid stays 0; req_ready is 0 for exactly 1 cycle.
- Flush:
  - Stimulus: dirty entries at (1,0) and (6,1); flush_start.
  - Required: beats from (1,0) then (6,1); flush_done pulses once, at cycle 16 + 2 + beats after start with wb_ready=1; afterwards all dirty masks are 0, so a re-flush produces no beats.
- Read-after-write:
  - Stimulus: write byteen=4'b1000, data 0x11223344 over fill word 0x55667788; read next cycle.
  - Required: rsp_data=0x11667788 one cycle after acceptance.
- Reset mid-drain:
  - Stimulus: assert reset during a stalled beat.
  - Required: wb_valid=0 next cycle; req_ready=1; a subsequent evict of the same entry emits no beats.
